// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter, branch resolution through a target LUT,
// IDLE/RUN/HALTED control and a saturating benchmark cycle counter.
module pc_branch_unit #(
  parameter int PC_WIDTH = 10,
  parameter int LUT_DEPTH = 16,
  parameter int START_ADDR = 0,
  localparam int IW = $clog2(LUT_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                flag_we,
  input  logic                equal_in,
  input  logic                less_than_in,
  input  logic [1:0]          branch_op,
  input  logic [IW-1:0]       target_idx,
  input  logic                halt_req,
  input  logic                lut_we,
  input  logic [IW-1:0]       lut_waddr,
  input  logic [PC_WIDTH-1:0] lut_wdata,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                branch_taken,
  output logic                running,
  output logic                done,
  output logic [15:0]         cycle_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  localparam logic [PC_WIDTH-1:0] START = PC_WIDTH'(START_ADDR);
  state_t state;
  logic flag_eq, flag_lt;
  logic [PC_WIDTH-1:0] lut [LUT_DEPTH];
  // Branches resolve on the registered flags so a same-cycle flag_we never affects them.
  always_comb begin
    branch_taken = state == RUN && !halt_req && !start &&
                   ((branch_op == 2'b01 && flag_eq) || (branch_op == 2'b10 && flag_lt) || branch_op == 2'b11);
  end
  assign running = state == RUN;
  assign done = state == HALTED;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc_out <= START;
      flag_eq <= 1'b0;
      flag_lt <= 1'b0;
      cycle_count <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else begin
      if (flag_we) {flag_eq, flag_lt} <= {equal_in, less_than_in};
      if (lut_we) lut[lut_waddr] <= lut_wdata;
      if (start) begin
        state <= RUN;
        pc_out <= START;
        cycle_count <= '0;
      end else if (state == RUN) begin
        cycle_count <= (&cycle_count) ? cycle_count : cycle_count + 16'd1;
        if (halt_req) state <= HALTED;
        else pc_out <= branch_taken ? lut[target_idx] : pc_out + PC_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed scenarios plus randomized traffic checked against
// an integer-level behavioural model of the PC/branch unit.
module tb_pc_branch_unit;
  logic clk = 0, reset = 1, start = 0, flag_we = 0, equal_in = 0, less_than_in = 0;
  logic [1:0] branch_op = 0;
  logic [3:0] target_idx = 0, lut_waddr = 0;
  logic halt_req = 0, lut_we = 0;
  logic [9:0] lut_wdata = 0, pc_out;
  logic branch_taken, running, done;
  logic [15:0] cycle_count;
  logic [27:0] act;
  int n_chk = 0, n_pass = 0;
  int m_st, m_pc, m_cnt;
  bit m_eq, m_lt;
  int m_lut [16];

  pc_branch_unit dut (
    .clk(clk), .reset(reset), .start(start), .flag_we(flag_we), .equal_in(equal_in),
    .less_than_in(less_than_in), .branch_op(branch_op), .target_idx(target_idx),
    .halt_req(halt_req), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc_out(pc_out), .branch_taken(branch_taken), .running(running), .done(done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;
  assign act = {pc_out, running, done, cycle_count};

  // Model: state 0=idle 1=run 2=halted; pc and counter as plain integers.
  function automatic bit m_taken();
    return m_st == 1 && !halt_req && !start &&
           ((branch_op == 1 && m_eq) || (branch_op == 2 && m_lt) || branch_op == 3);
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [9:0] p = m_pc[9:0];
    logic [15:0] c = m_cnt[15:0];
    return {p, m_st == 1, m_st == 2, c};
  endfunction

  task automatic m_reset();
    m_st = 0; m_pc = 0; m_cnt = 0; m_eq = 0; m_lt = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic idle_in();
    start = 0; flag_we = 0; equal_in = 0; less_than_in = 0; branch_op = 0;
    target_idx = 0; halt_req = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic tick();
    bit tk;
    tk = m_taken();
    if (start) begin
      m_st = 1; m_pc = 0; m_cnt = 0;
    end else if (m_st == 1) begin
      m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      if (halt_req) m_st = 2;
      else m_pc = tk ? m_lut[target_idx] : (m_pc + 1) % 1024;
    end
    if (flag_we) begin m_eq = equal_in; m_lt = less_than_in; end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    branch_op = 3;
    #2;
    n_chk++; if (act !== 28'd0 || branch_taken !== 1'b0) $display("FAIL reset_state got %h/%b exp 0/0", act, branch_taken); else n_pass++;
    m_reset();
    @(negedge clk); reset = 0; idle_in();
  endtask

  task automatic test_run_seq();
    start = 1; tick(); start = 0;
    n_chk++; if (act !== exp_vec() || pc_out !== 10'd0) $display("FAIL start got %h exp %h", act, exp_vec()); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      n_chk++; if (branch_taken !== 1'b0) $display("FAIL seq_taken got %b exp 0", branch_taken); else n_pass++;
      tick();
      n_chk++; if (pc_out !== 10'(i) || act !== exp_vec()) $display("FAIL seq_pc got %h exp %h", act, exp_vec()); else n_pass++;
    end
    n_chk++; if (cycle_count !== 16'd5) $display("FAIL seq_cnt got %0d exp 5", cycle_count); else n_pass++;
  endtask

  task automatic test_beq();
    lut_we = 1; lut_waddr = 3; lut_wdata = 10'h120; flag_we = 1; equal_in = 1; tick(); idle_in();
    branch_op = 1; target_idx = 3; #1;
    n_chk++; if (branch_taken !== 1'b1) $display("FAIL beq_taken got %b exp 1", branch_taken); else n_pass++;
    tick();
    n_chk++; if (pc_out !== 10'h120 || act !== exp_vec()) $display("FAIL beq_pc got %h exp %h", act, exp_vec()); else n_pass++;
    idle_in(); flag_we = 1; equal_in = 0; tick(); idle_in();
    branch_op = 1; target_idx = 3; #1;
    n_chk++; if (branch_taken !== 1'b0) $display("FAIL beq_nt_taken got %b exp 0", branch_taken); else n_pass++;
    tick();
    n_chk++; if (pc_out !== 10'h122 || act !== exp_vec()) $display("FAIL beq_nt_pc got %h exp %h", act, exp_vec()); else n_pass++;
  endtask

  task automatic test_blt_same_cycle();
    idle_in(); flag_we = 1; less_than_in = 1; branch_op = 2; target_idx = 3; #1;
    n_chk++; if (branch_taken !== 1'b0) $display("FAIL blt_old_flag got %b exp 0", branch_taken); else n_pass++;
    tick();
    n_chk++; if (pc_out !== 10'h123 || act !== exp_vec()) $display("FAIL blt_old_pc got %h exp %h", act, exp_vec()); else n_pass++;
    idle_in(); branch_op = 2; target_idx = 3; #1;
    n_chk++; if (branch_taken !== 1'b1) $display("FAIL blt_new_flag got %b exp 1", branch_taken); else n_pass++;
    tick();
    n_chk++; if (pc_out !== 10'h120) $display("FAIL blt_new_pc got %h exp 120", pc_out); else n_pass++;
  endtask

  task automatic test_wrap();
    idle_in(); lut_we = 1; lut_waddr = 0; lut_wdata = 10'h3FF; tick();
    idle_in(); branch_op = 3; target_idx = 0; tick();
    n_chk++; if (pc_out !== 10'h3FF) $display("FAIL wrap_jump got %h exp 3ff", pc_out); else n_pass++;
    idle_in(); tick();
    n_chk++; if (pc_out !== 10'h000 || act !== exp_vec()) $display("FAIL wrap got %h exp %h", act, exp_vec()); else n_pass++;
  endtask

  task automatic test_same_index();
    idle_in(); lut_we = 1; lut_waddr = 5; lut_wdata = 10'h2AA; tick();
    lut_wdata = 10'h155; branch_op = 3; target_idx = 5; tick();
    n_chk++; if (pc_out !== 10'h2AA) $display("FAIL lut_rw_old got %h exp 2aa", pc_out); else n_pass++;
    idle_in(); branch_op = 3; target_idx = 5; tick();
    n_chk++; if (pc_out !== 10'h155) $display("FAIL lut_rw_new got %h exp 155", pc_out); else n_pass++;
  endtask

  task automatic test_halt();
    logic [15:0] c;
    idle_in(); lut_we = 1; lut_waddr = 1; lut_wdata = 10'h010; tick();
    idle_in(); branch_op = 3; target_idx = 1; tick();
    halt_req = 1; #1;
    n_chk++; if (branch_taken !== 1'b0) $display("FAIL halt_taken got %b exp 0", branch_taken); else n_pass++;
    c = cycle_count + 16'd1;
    tick();
    n_chk++; if (pc_out !== 10'h010 || done !== 1'b1 || running !== 1'b0 || cycle_count !== c) $display("FAIL halt_enter got %h exp pc 010 done 1 cnt %h", act, c); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      branch_op = 2'($urandom); halt_req = 1'($urandom); flag_we = 1; equal_in = 1; less_than_in = 1;
      tick();
      n_chk++; if (act !== exp_vec() || cycle_count !== c) $display("FAIL halt_hold got %h exp %h", act, exp_vec()); else n_pass++;
    end
    idle_in(); start = 1; tick(); start = 0;
    n_chk++; if (pc_out !== 10'd0 || running !== 1'b1 || done !== 1'b0 || cycle_count !== 16'd0) $display("FAIL halt_restart got %h exp 0 run 1 done 0 cnt 0", act); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start = $urandom_range(0, 24) == 0; halt_req = $urandom_range(0, 15) == 0;
      flag_we = 1'($urandom); equal_in = 1'($urandom); less_than_in = 1'($urandom);
      branch_op = 2'($urandom); target_idx = 4'($urandom);
      lut_we = $urandom_range(0, 3) == 0; lut_waddr = 4'($urandom); lut_wdata = 10'($urandom);
      #1;
      n_chk++; if (branch_taken !== m_taken()) $display("FAIL rand_taken cyc %0d got %b exp %b", i, branch_taken, m_taken()); else n_pass++;
      tick();
      n_chk++; if (act !== exp_vec()) $display("FAIL rand_state cyc %0d got %h exp %h", i, act, exp_vec()); else n_pass++;
    end
    idle_in();
  endtask

  task automatic test_async_reset();
    idle_in(); start = 1; tick(); idle_in();
    lut_we = 1; lut_waddr = 2; lut_wdata = 10'h055; flag_we = 1; equal_in = 1; less_than_in = 1; tick();
    idle_in(); branch_op = 3; target_idx = 2; tick();
    n_chk++; if (pc_out !== 10'h055) $display("FAIL areset_setup got %h exp 055", pc_out); else n_pass++;
    @(negedge clk); #2; reset = 1; #1;
    n_chk++; if (act !== 28'd0 || branch_taken !== 1'b0) $display("FAIL areset_immediate got %h/%b exp 0/0", act, branch_taken); else n_pass++;
    m_reset();
    @(negedge clk); reset = 0; idle_in();
    start = 1; tick(); idle_in();
    branch_op = 1; target_idx = 2; #1;
    n_chk++; if (branch_taken !== 1'b0) $display("FAIL areset_flag_eq got %b exp 0", branch_taken); else n_pass++;
    branch_op = 2; #1;
    n_chk++; if (branch_taken !== 1'b0) $display("FAIL areset_flag_lt got %b exp 0", branch_taken); else n_pass++;
    tick();
    branch_op = 3; target_idx = 2; tick();
    n_chk++; if (pc_out !== 10'd0 || act !== exp_vec()) $display("FAIL areset_lut got %h exp %h", act, exp_vec()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_run_seq();
    test_beq();
    test_blt_same_cycle();
    test_wrap();
    test_same_index();
    test_halt();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
